// File: rtl/axi_dma_sched_pkg.sv
// rtl/axi_dma_sched_pkg.sv - shared types and helpers for the AXI DMA burst scheduler
// Purpose: burst-type enum, 4 KB constant, channel slot and burst descriptor
//          structs, and the bytes-to-4KB-boundary helper.
// Ports:   none (package).
// Note:    struct field widths follow SCHED_ADDR_WD / SCHED_LEN_WD, which are
//          also the defaults of the scheduler's ADDR_WD / LEN_WD parameters.
package axi_dma_sched_pkg;

  localparam int AXI_4K_BYTES  = 4096;
  localparam int SCHED_ADDR_WD = 32;
  localparam int SCHED_LEN_WD  = 16;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef struct packed {
    logic [SCHED_ADDR_WD-1:0] src;
    logic [SCHED_ADDR_WD-1:0] dst;
    logic [SCHED_LEN_WD-1:0]  remaining;
    logic [2:0]               size;
    burst_e                   burst;
    logic                     full;
  } chan_slot_t;

  typedef struct packed {
    logic [SCHED_ADDR_WD-1:0] src;
    logic [SCHED_ADDR_WD-1:0] dst;
    logic [7:0]               len;
    logic [2:0]               size;
    burst_e                   burst;
    logic                     last;
  } burst_desc_t;

  // WRAP and the reserved encoding are carried as INCR from accept onwards.
  function automatic burst_e norm_burst(input logic [1:0] b);
    return (b == 2'b00) ? BURST_FIXED : BURST_INCR;
  endfunction

  // Beats of 2**size bytes that fit before the next 4 KB boundary.
  function automatic logic [12:0] beats_to_4k(input logic [11:0] off,
                                              input logic [2:0]  size);
    logic [12:0] bytes;
    bytes = 13'(AXI_4K_BYTES) - {1'b0, off};
    return bytes >> size;
  endfunction

endpackage

// File: rtl/axi_dma_rr_arbiter.sv
// rtl/axi_dma_rr_arbiter.sv - round-robin request picker
// Purpose: grants the first asserted request at or after ptr, wrapping modulo N.
// Ports:   req   - request vector
//          ptr   - search start index (must be < N)
//          gnt   - one-hot grant
//          idx   - granted index
//          found - any request asserted
module axi_dma_rr_arbiter #(
  parameter int N      = 8,
  parameter int IDX_WD = 3
) (
  input  logic [N-1:0]      req,
  input  logic [IDX_WD-1:0] ptr,
  output logic [N-1:0]      gnt,
  output logic [IDX_WD-1:0] idx,
  output logic              found
);

  int j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_WD'(j);
      end
    end
  end

endmodule

// File: rtl/axi_dma_burst_scheduler.sv
// rtl/axi_dma_burst_scheduler.sv - multi-channel DMA command to AXI burst splitter
// Purpose: holds one command per channel, grants one burst per channel
//          round-robin, and cuts each command into bursts of at most
//          MAX_BURST_LEN beats that never cross a 4 KB boundary.
// Ports:   clk, rst (async, active-low)
//          cmd_*      - per-channel command slots, cmd_ready = slot empty
//          bst_*      - burst descriptor stream (valid/ready)
//          chan_done  - one-cycle pulse when a channel's last burst is taken
//          chan_prio  - per-channel high-priority flag (AXI_DMA_SCHED_PRIO_EN only)
// Option:  AXI_DMA_SCHED_PRIO_EN - strict two-class priority, each class round-robin.
module axi_dma_burst_scheduler
  import axi_dma_sched_pkg::*;
#(
  parameter int ADDR_WD       = SCHED_ADDR_WD,
  parameter int CHANNEL_COUNT = 8,
  parameter int MAX_BURST_LEN = 16,
  parameter int LEN_WD        = SCHED_LEN_WD,
  parameter int CH_WD         = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHANNEL_COUNT-1:0]         cmd_valid,
  input  logic [CHANNEL_COUNT*ADDR_WD-1:0] cmd_src_addr,
  input  logic [CHANNEL_COUNT*ADDR_WD-1:0] cmd_dst_addr,
  input  logic [CHANNEL_COUNT*2-1:0]       cmd_burst,
  input  logic [CHANNEL_COUNT*LEN_WD-1:0]  cmd_len,
  input  logic [CHANNEL_COUNT*3-1:0]       cmd_size,
  output logic [CHANNEL_COUNT-1:0]         cmd_ready,
`ifdef AXI_DMA_SCHED_PRIO_EN
  input  logic [CHANNEL_COUNT-1:0]         chan_prio,
`endif
  output logic                          bst_valid,
  input  logic                          bst_ready,
  output logic [CH_WD-1:0]              bst_chan,
  output logic [ADDR_WD-1:0]            bst_src_addr,
  output logic [ADDR_WD-1:0]            bst_dst_addr,
  output logic [7:0]                    bst_len,
  output logic [2:0]                    bst_size,
  output logic [1:0]                    bst_burst,
  output logic                          bst_last,
  output logic [CHANNEL_COUNT-1:0]      chan_done
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ISSUE} state_e;

  state_e                   state_q, state_d;
  chan_slot_t               slot_q [CHANNEL_COUNT];
  logic [CHANNEL_COUNT-1:0] full_vec;
  logic [CH_WD-1:0]         grant_q;
  logic [CHANNEL_COUNT-1:0] grant_oh_q;
  logic [8:0]               beats_q;
  burst_desc_t              desc_q;
  burst_desc_t              calc_desc;
  logic [8:0]               beats_c;
  logic [12:0]              src_room;
  logic [12:0]              dst_room;
  logic                     bst_valid_q;
  logic [CHANNEL_COUNT-1:0] done_q;
  logic                     bst_hs;

  logic                     arb_any;
  logic [CH_WD-1:0]         arb_idx;
  logic [CHANNEL_COUNT-1:0] arb_gnt;

  function automatic logic [CH_WD-1:0] ptr_after(input logic [CH_WD-1:0] idx);
    return (int'(idx) >= CHANNEL_COUNT - 1) ? '0 : idx + CH_WD'(1);
  endfunction

  always_comb begin
    full_vec = '0;
    for (int i = 0; i < CHANNEL_COUNT; i++) full_vec[i] = slot_q[i].full;
  end

  // Registered slot state, so a slot freed this cycle cannot be refilled
  // until the next one.
  assign cmd_ready = ~full_vec;

  // ---------------------------------------------------------------- arbitration
`ifdef AXI_DMA_SCHED_PRIO_EN
  logic [CH_WD-1:0]         rr_hi_q, rr_lo_q;
  logic [CHANNEL_COUNT-1:0] gnt_hi, gnt_lo;
  logic [CH_WD-1:0]         idx_hi, idx_lo;
  logic                     any_hi, any_lo;

  axi_dma_rr_arbiter #(.N(CHANNEL_COUNT), .IDX_WD(CH_WD)) u_arb_hi (
    .req(full_vec & chan_prio), .ptr(rr_hi_q), .gnt(gnt_hi), .idx(idx_hi), .found(any_hi)
  );
  axi_dma_rr_arbiter #(.N(CHANNEL_COUNT), .IDX_WD(CH_WD)) u_arb_lo (
    .req(full_vec & ~chan_prio), .ptr(rr_lo_q), .gnt(gnt_lo), .idx(idx_lo), .found(any_lo)
  );

  assign arb_any = any_hi | any_lo;
  assign arb_gnt = any_hi ? gnt_hi : gnt_lo;
  assign arb_idx = any_hi ? idx_hi : idx_lo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_hi_q <= '0;
      rr_lo_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (any_hi)      rr_hi_q <= ptr_after(idx_hi);
      else if (any_lo) rr_lo_q <= ptr_after(idx_lo);
    end
  end
`else
  logic [CH_WD-1:0] rr_ptr_q;

  axi_dma_rr_arbiter #(.N(CHANNEL_COUNT), .IDX_WD(CH_WD)) u_arb (
    .req(full_vec), .ptr(rr_ptr_q), .gnt(arb_gnt), .idx(arb_idx), .found(arb_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= '0;
    end else if (state_q == S_IDLE && arb_any) begin
      rr_ptr_q <= ptr_after(arb_idx);
    end
  end
`endif

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (arb_any)   state_d = S_CALC;
      S_CALC:                 state_d = S_ISSUE;
      S_ISSUE: if (bst_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- burst sizing
  always_comb begin
    src_room = beats_to_4k(slot_q[grant_q].src[11:0], slot_q[grant_q].size);
    dst_room = beats_to_4k(slot_q[grant_q].dst[11:0], slot_q[grant_q].size);
    beats_c  = (slot_q[grant_q].remaining > LEN_WD'(MAX_BURST_LEN)) ?
               9'(MAX_BURST_LEN) : 9'(slot_q[grant_q].remaining);
    if (slot_q[grant_q].burst != BURST_FIXED) begin
      if ({4'b0, beats_c} > src_room) beats_c = src_room[8:0];
      if ({4'b0, beats_c} > dst_room) beats_c = dst_room[8:0];
    end
    // A misaligned address within one beat of a boundary yields zero room;
    // still move one beat so the channel always makes progress.
    if (beats_c == '0) beats_c = 9'd1;

    calc_desc.src   = slot_q[grant_q].src;
    calc_desc.dst   = slot_q[grant_q].dst;
    calc_desc.len   = 8'(beats_c - 9'd1);
    calc_desc.size  = slot_q[grant_q].size;
    calc_desc.burst = slot_q[grant_q].burst;
    calc_desc.last  = (slot_q[grant_q].remaining == LEN_WD'(beats_c));
  end

  assign bst_hs = bst_valid_q && bst_ready;

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CHANNEL_COUNT; i++) slot_q[i] <= '0;
      grant_q     <= '0;
      grant_oh_q  <= '0;
      beats_q     <= '0;
      desc_q      <= '0;
      bst_valid_q <= 1'b0;
      done_q      <= '0;
    end else begin
      done_q <= '0;

      for (int i = 0; i < CHANNEL_COUNT; i++) begin
        if (cmd_valid[i] && !slot_q[i].full) begin
          if (cmd_len[i*LEN_WD +: LEN_WD] == '0) begin
            done_q[i] <= 1'b1;
          end else begin
            slot_q[i].src       <= cmd_src_addr[i*ADDR_WD +: ADDR_WD];
            slot_q[i].dst       <= cmd_dst_addr[i*ADDR_WD +: ADDR_WD];
            slot_q[i].remaining <= cmd_len[i*LEN_WD +: LEN_WD];
            slot_q[i].size      <= cmd_size[i*3 +: 3];
            slot_q[i].burst     <= norm_burst(cmd_burst[i*2 +: 2]);
            slot_q[i].full      <= 1'b1;
          end
        end else if (bst_hs && grant_oh_q[i]) begin
          slot_q[i].remaining <= slot_q[i].remaining - LEN_WD'(beats_q);
          if (slot_q[i].burst != BURST_FIXED) begin
            slot_q[i].src <= slot_q[i].src + (ADDR_WD'(beats_q) << slot_q[i].size);
            slot_q[i].dst <= slot_q[i].dst + (ADDR_WD'(beats_q) << slot_q[i].size);
          end
          if (desc_q.last) begin
            slot_q[i].full <= 1'b0;
            done_q[i]      <= 1'b1;
          end
        end
      end

      case (state_q)
        S_IDLE: begin
          if (arb_any) begin
            grant_q    <= arb_idx;
            grant_oh_q <= arb_gnt;
          end
        end
        S_CALC: begin
          desc_q      <= calc_desc;
          beats_q     <= beats_c;
          bst_valid_q <= 1'b1;
        end
        S_ISSUE: begin
          if (bst_ready) bst_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bst_valid    = bst_valid_q;
  assign bst_chan     = grant_q;
  assign bst_src_addr = desc_q.src;
  assign bst_dst_addr = desc_q.dst;
  assign bst_len      = desc_q.len;
  assign bst_size     = desc_q.size;
  assign bst_burst    = desc_q.burst;
  assign bst_last     = desc_q.last;
  assign chan_done    = done_q;

endmodule

// File: tb/tb_axi_dma_burst_scheduler.sv
// tb/tb_axi_dma_burst_scheduler.sv - scoreboard bench for axi_dma_burst_scheduler
`timescale 1ns/1ps
module tb_axi_dma_burst_scheduler;

  localparam int AW  = 32;
  localparam int NCH = 8;
  localparam int LW  = 16;
  localparam int CW  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    cmd_valid;
  logic [NCH*AW-1:0] cmd_src_addr;
  logic [NCH*AW-1:0] cmd_dst_addr;
  logic [NCH*2-1:0]  cmd_burst;
  logic [NCH*LW-1:0] cmd_len;
  logic [NCH*3-1:0]  cmd_size;
  logic [NCH-1:0]    cmd_ready;
  logic              bst_valid;
  logic              bst_ready;
  logic [CW-1:0]     bst_chan;
  logic [AW-1:0]     bst_src_addr;
  logic [AW-1:0]     bst_dst_addr;
  logic [7:0]        bst_len;
  logic [2:0]        bst_size;
  logic [1:0]        bst_burst;
  logic              bst_last;
  logic [NCH-1:0]    chan_done;

  always #5 clk = ~clk;

  axi_dma_burst_scheduler dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_src_addr(cmd_src_addr), .cmd_dst_addr(cmd_dst_addr),
    .cmd_burst(cmd_burst), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_ready(cmd_ready),
    .bst_valid(bst_valid), .bst_ready(bst_ready), .bst_chan(bst_chan),
    .bst_src_addr(bst_src_addr), .bst_dst_addr(bst_dst_addr), .bst_len(bst_len),
    .bst_size(bst_size), .bst_burst(bst_burst), .bst_last(bst_last), .chan_done(chan_done)
  );

  typedef struct packed {
    logic [CW-1:0] chan;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [1:0]    burst;
    logic          last;
  } exp_t;

  exp_t           sb[$];
  int             total = 0;
  int             bad = 0;
  int             done_cnt [NCH];
  logic [NCH-1:0] exp_done_mask = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int ch, input logic [31:0] s, input logic [31:0] d,
                      input logic [7:0] len, input logic [1:0] b, input logic last);
    exp_t e;
    e.chan = CW'(ch); e.src = s; e.dst = d; e.len = len;
    e.size = 3'd2; e.burst = b; e.last = last;
    sb.push_back(e);
  endtask

  task automatic set_cmd(input int ch, input logic [31:0] s, input logic [31:0] d,
                         input logic [1:0] b, input logic [15:0] len);
    cmd_valid[ch]           = 1'b1;
    cmd_src_addr[ch*AW +: AW] = s;
    cmd_dst_addr[ch*AW +: AW] = d;
    cmd_burst[ch*2 +: 2]    = b;
    cmd_len[ch*LW +: LW]    = len;
    cmd_size[ch*3 +: 3]     = 3'd2;
  endtask

  task automatic fire();
    @(posedge clk); #1;
    cmd_valid = '0;
  endtask

  task automatic clear_done();
    for (int i = 0; i < NCH; i++) done_cnt[i] = 0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || bst_valid) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 2000) begin
      total++;
      bad++;
      $display("FAIL %s_drain actual=%0d_left required=0_left", name, sb.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cmd_valid = '0;
    bst_ready = 1'b1;
    sb.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // Monitor: pops the scoreboard on every handshake, checks held descriptors
  // and expected completion pulses.
  initial begin : monitor
    exp_t cur;
    exp_t held;
    exp_t e;
    logic hold;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold = 1'b0;
        exp_done_mask = '0;
      end else begin
        if (exp_done_mask != '0) begin
          check("done_pulse", 128'(chan_done & exp_done_mask), 128'(exp_done_mask));
          check("done_ready", 128'(cmd_ready & exp_done_mask), 128'(exp_done_mask));
          exp_done_mask = '0;
        end
        for (int i = 0; i < NCH; i++) if (chan_done[i]) done_cnt[i]++;
        cur.chan = bst_chan; cur.src = bst_src_addr; cur.dst = bst_dst_addr;
        cur.len = bst_len; cur.size = bst_size; cur.burst = bst_burst; cur.last = bst_last;
        if (hold) begin
          check("hold_valid", 128'(bst_valid), 128'(1'b1));
          check("hold_stable", 128'(cur), 128'(held));
        end
        hold = 1'b0;
        if (bst_valid && bst_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_burst actual=0x%0h required=none", cur);
          end else begin
            e = sb.pop_front();
            check("burst", 128'(cur), 128'(e));
            if (e.last) exp_done_mask[e.chan] = 1'b1;
          end
        end else if (bst_valid) begin
          hold = 1'b1;
          held = cur;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin : stim
    int n;
    rst = 1'b0;
    cmd_valid = '0;
    cmd_src_addr = '0;
    cmd_dst_addr = '0;
    cmd_burst = '0;
    cmd_len = '0;
    cmd_size = '0;
    bst_ready = 1'b1;
    clear_done();
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_cmd_ready", 128'(cmd_ready), 128'(8'hFF));
    check("rst_bst_valid", 128'(bst_valid), 128'(1'b0));
    check("rst_chan_done", 128'(chan_done), 128'(8'h00));
    check("rst_bst_fields", 128'({bst_chan, bst_src_addr, bst_dst_addr, bst_len, bst_last}), 128'(0));
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid", 128'(bst_valid), 128'(1'b0));

    // ch0: 100 beats -> 6 x 16 + 4, steps of 0x40
    clear_done();
    for (int k = 0; k < 7; k++)
      push(0, 32'h1234_0000 + 32'(k * 64), 32'h3456_0000 + 32'(k * 64),
           (k == 6) ? 8'd3 : 8'd15, 2'b01, k == 6);
    set_cmd(0, 32'h1234_0000, 32'h3456_0000, 2'b01, 16'd100);
    fire();
    check("t1_ready_drop", 128'(cmd_ready[0]), 128'(1'b0));
    check("t1_lat_accept", 128'(bst_valid), 128'(1'b0));
    @(posedge clk); #1;
    check("t1_lat_grant", 128'(bst_valid), 128'(1'b0));
    @(posedge clk); #1;
    check("t1_lat_calc", 128'(bst_valid), 128'(1'b1));
    drain("t1");
    check("t1_done_cnt", 128'(done_cnt[0]), 128'(1));
    check("t1_ready_back", 128'(cmd_ready[0]), 128'(1'b1));

    // ch1: source crosses 4 KB after 4 beats
    clear_done();
    push(1, 32'h0000_0FF0, 32'h0000_2000, 8'd3, 2'b01, 1'b0);
    push(1, 32'h0000_1000, 32'h0000_2010, 8'd11, 2'b01, 1'b1);
    set_cmd(1, 32'h0000_0FF0, 32'h0000_2000, 2'b01, 16'd16);
    fire();
    drain("t2");
    check("t2_done_cnt", 128'(done_cnt[1]), 128'(1));

    // ch2: FIXED, 40 beats -> 16,16,8 at unchanged addresses
    clear_done();
    push(2, 32'h0000_0100, 32'h0000_0200, 8'd15, 2'b00, 1'b0);
    push(2, 32'h0000_0100, 32'h0000_0200, 8'd15, 2'b00, 1'b0);
    push(2, 32'h0000_0100, 32'h0000_0200, 8'd7, 2'b00, 1'b1);
    set_cmd(2, 32'h0000_0100, 32'h0000_0200, 2'b00, 16'd40);
    fire();
    drain("t3");
    check("t3_done_cnt", 128'(done_cnt[2]), 128'(1));

    // ch0/ch3/ch5 together, interleaved per burst, with a 5-cycle stall
    do_reset();
    clear_done();
    push(0, 32'h0000_1000, 32'h0000_8000, 8'd15, 2'b01, 1'b0);
    push(3, 32'h0000_3000, 32'h0000_9000, 8'd15, 2'b01, 1'b0);
    push(5, 32'h0000_5000, 32'h0000_A000, 8'd15, 2'b01, 1'b0);
    push(0, 32'h0000_1040, 32'h0000_8040, 8'd15, 2'b01, 1'b1);
    push(3, 32'h0000_3040, 32'h0000_9040, 8'd15, 2'b01, 1'b1);
    push(5, 32'h0000_5040, 32'h0000_A040, 8'd15, 2'b01, 1'b1);
    set_cmd(0, 32'h0000_1000, 32'h0000_8000, 2'b01, 16'd32);
    set_cmd(3, 32'h0000_3000, 32'h0000_9000, 2'b01, 16'd32);
    set_cmd(5, 32'h0000_5000, 32'h0000_A000, 2'b01, 16'd32);
    fire();
    repeat (4) @(posedge clk);
    #1 bst_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 bst_ready = 1'b1;
    drain("t4");
    check("t4_done_cnt", 128'({done_cnt[0][7:0], done_cnt[3][7:0], done_cnt[5][7:0]}), 128'(24'h010101));

    // ch4: zero-length command completes without a burst
    clear_done();
    set_cmd(4, 32'h0000_4000, 32'h0000_4400, 2'b01, 16'd0);
    fire();
    check("t5_done_pulse", 128'(chan_done), 128'(8'h10));
    check("t5_ready_kept", 128'(cmd_ready[4]), 128'(1'b1));
    @(posedge clk); #1;
    check("t5_done_clear", 128'(chan_done), 128'(8'h00));
    check("t5_ready_all", 128'(cmd_ready), 128'(8'hFF));
    repeat (3) @(posedge clk);
    #1;
    check("t5_no_burst", 128'(bst_valid), 128'(1'b0));
    check("t5_done_cnt", 128'(done_cnt[4]), 128'(1));

    // Reset while ch0 is stuck in ISSUE
    clear_done();
    bst_ready = 1'b0;
    set_cmd(0, 32'h0000_4000, 32'h0000_6000, 2'b01, 16'd32);
    fire();
    n = 0;
    while (!bst_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("t6_in_issue", 128'(bst_valid), 128'(1'b1));
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check("t6_rst_valid", 128'(bst_valid), 128'(1'b0));
    check("t6_rst_ready", 128'(cmd_ready), 128'(8'hFF));
    check("t6_rst_done", 128'(chan_done), 128'(8'h00));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    bst_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t6_no_done", 128'(done_cnt[0]), 128'(0));
    push(0, 32'h0000_7000, 32'h0000_8000, 8'd15, 2'b01, 1'b1);
    push(2, 32'h0000_9000, 32'h0000_A000, 8'd15, 2'b01, 1'b1);
    set_cmd(0, 32'h0000_7000, 32'h0000_8000, 2'b01, 16'd16);
    set_cmd(2, 32'h0000_9000, 32'h0000_A000, 2'b01, 16'd16);
    fire();
    drain("t6");
    check("t6_done_cnt", 128'({done_cnt[0][7:0], done_cnt[2][7:0]}), 128'(16'h0101));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_dma_burst_scheduler.md
Name: axi_dma_burst_scheduler

Overview:
- Multi-channel command front end for the AXI DMA datapath.
- Accepts one DMA command per channel and holds per-channel transfer state.
- Arbitrates round-robin per burst across channels and splits each command into AXI-legal burst descriptors (≤ MAX_BURST_LEN beats, no 4 KB crossing).
- Descriptors go to the downstream read/write engines.

Parameters:
- ADDR_WD, 32, address width
- CHANNEL_COUNT, 8, number of command channels (≥1)
- MAX_BURST_LEN, 16, max beats per emitted burst (1..256)
- LEN_WD, 16, width of command beat count
- CH_WD, $clog2(CHANNEL_COUNT) (min 1), channel index width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- cmd_valid  in  CHANNEL_COUNT  per-channel command valid
- cmd_src_addr  in  CHANNEL_COUNT*ADDR_WD  per-channel source start address
- cmd_dst_addr  in  CHANNEL_COUNT*ADDR_WD  per-channel destination start address
- cmd_burst  in  CHANNEL_COUNT*2  per-channel AXI burst type (FIXED/INCR)
- cmd_len  in  CHANNEL_COUNT*LEN_WD  per-channel total beats
- cmd_size  in  CHANNEL_COUNT*3  per-channel AXI size (log2 bytes/beat)
- cmd_ready  out  CHANNEL_COUNT  channel slot empty
- bst_valid  out  1  burst descriptor valid
- bst_ready  in  1  downstream accepts descriptor
- bst_chan  out  CH_WD  owning channel
- bst_src_addr  out  ADDR_WD  burst source address
- bst_dst_addr  out  ADDR_WD  burst destination address
- bst_len  out  8  AXI LEN encoding (beats-1)
- bst_size  out  3  AXI size
- bst_burst  out  2  AXI burst type
- bst_last  out  1  final burst of the command
- chan_done  out  CHANNEL_COUNT  one-cycle pulse when channel's last burst is accepted

Behaviour:
- Reset (rst=0, async): all slots empty, cmd_ready all 1, bst_* all 0, chan_done 0, RR pointer 0, FSM IDLE. Reset mid-transfer drops all pending work, with no completion pulse.
- Slot accept: cmd_valid[i]&&cmd_ready[i] latches src, dst, burst, size, remaining=cmd_len. cmd_ready[i] drops next cycle.
  - cmd_len==0: slot is never filled, cmd_ready stays 1, chan_done[i] pulses next cycle, no burst is emitted.
- WRAP (2'b10) and reserved (2'b11) burst types are treated as INCR.
- FSM IDLE: if any slot is full, grant the first full channel at or after the RR pointer, then go to CALC. The RR pointer becomes grant+1 (mod CHANNEL_COUNT).
- FSM CALC, one cycle:
  - beats = min(remaining, MAX_BURST_LEN, src4k, dst4k), where x4k = (4096 - addr[11:0]) >> size.
  - For FIXED, src4k and dst4k are ignored.
  - Register descriptor, then go to ISSUE.
- FSM ISSUE:
  - bst_valid=1. Descriptor fields are held stable until bst_ready; bst_valid never drops without a handshake.
  - On handshake:
    - remaining -= beats.
    - For INCR, src and dst each advance by beats<<size (modulo 2^ADDR_WD).
    - For FIXED, addresses are unchanged.
    - If remaining becomes 0: bst_last=1 on that descriptor, slot freed, chan_done pulse in the handshake cycle +1, cmd_ready[i]=1 same cycle as the chan_done pulse.
    - Go to IDLE.
- Latency: command accept to first bst_valid = 3 cycles (accept, IDLE/grant, CALC). Peak rate is one descriptor per 3 cycles.
- Bursts interleave: each grant emits exactly one burst, so channels share bandwidth per burst.
- A new command on channel i while its slot is busy is backpressured. A command accepted in the same cycle a slot frees is not possible, because cmd_ready is registered.
- Addresses are expected aligned to size. Misaligned low bits pass through unmodified; only the 4 KB computation uses them.

Optional Feature:
- Macro: AXI_DMA_SCHED_PRIO_EN.
- Defined: adds input chan_prio[CHANNEL_COUNT] (1 = high).
  - IDLE grants round-robin among full high-priority slots first.
  - Low-priority slots are granted only when no high-priority slot is full.
  - Separate RR pointers per class.
- Undefined: port absent, pure round-robin as above.

Decomposition:
- Package axi_dma_sched_pkg:
  - burst-type enum (FIXED/INCR/WRAP).
  - AXI_4K_BYTES=4096 constant.
  - Channel slot struct typedef (src, dst, remaining, size, burst, full).
  - Descriptor struct typedef.
- One sub-module: axi_dma_rr_arbiter (request vector, pointer → one-hot grant + index), instantiated twice under AXI_DMA_SCHED_PRIO_EN.

Test Plan:
- ch0 src=0x12340000 dst=0x34560000 INCR len=100 size=2 → 7 descriptors: 6×LEN=15 then LEN=3 with bst_last. src steps +0x40, dst steps +0x40. chan_done[0] pulses once.
- ch1 src=0x00000FF0 dst=0x00002000 INCR len=16 size=2 → LEN=3 @0xFF0/0x2000, then LEN=11 @0x1000/0x2010 (4 KB split on src).
- ch2 FIXED src=0x100 len=40 size=2 → LEN=15,15,7. All src=0x100, all dst unchanged.
- ch0, ch3, ch5 loaded in the same cycle, each len=32 → bst_chan order 0,3,5,0,3,5, with bst_ready held low 5 cycles mid-stream and descriptor stable throughout.
- cmd_len=0 on ch4 → chan_done[4] next cycle, no bst_valid, cmd_ready[4] stays 1.
- Assert rst during ISSUE of ch0 → bst_valid=0 immediately, all cmd_ready=1, no chan_done, first grant after release is ch0 pointer.
